// File: rtl/adder_share_arb.sv
// rtl/adder_share_arb.sv - one W-bit adder time-shared by NREQ requesters via round-robin
// Optional carry-in per requester: define ADDER_SHARE_ARB_CIN_EN
module adder_share_arb #(
  parameter int NREQ = 4,
  parameter int W = 12,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
`ifdef ADDER_SHARE_ARB_CIN_EN
  input  logic [NREQ-1:0]     req_cin,
`endif
  output logic                res_valid,
  input  logic                res_ready,
  output logic [W:0]          res_sum,
  output logic [IDW-1:0]      res_id
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t         state, state_next;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] idx;
  logic           found;
  logic           drain;
  logic           accept;
  logic [W-1:0]   a_sel, b_sel;
  logic           cin;
  logic [W:0]     sum_next;

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // First valid requester at or above rr_ptr, wrapping past NREQ-1
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = wrap_idx(rr_ptr, k);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  assign res_valid = (state == FULL);
  assign drain     = res_valid & res_ready;
  // Reset cycles never transfer, so accept is masked by rst_n
  assign accept    = rst_n & ((state == EMPTY) | drain) & found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  assign a_sel = req_a[grant*W +: W];
  assign b_sel = req_b[grant*W +: W];

`ifdef ADDER_SHARE_ARB_CIN_EN
  assign cin = req_cin[grant];
`else
  assign cin = 1'b0;
`endif

  assign sum_next = {1'b0, a_sel} + {1'b0, b_sel} + {{W{1'b0}}, cin};

  always_comb begin
    state_next = state;
    if (accept)     state_next = FULL;
    else if (drain) state_next = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= EMPTY;
      res_sum <= '0;
      res_id  <= '0;
      rr_ptr  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        res_sum <= sum_next;
        res_id  <= grant;
        rr_ptr  <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
      end
    end
  end

endmodule
